// File: rtl/wb_dram_arbiter.sv
// wb_dram_arbiter: round-robin arbiter sharing the DRAM wrapper's single Wishbone slave port
// among NUM_MASTERS requesters. Each grant covers one complete cyc/stb -> ack transaction. The
// winning request is registered toward the wrapper, and the ack and read data are steered back
// to the granted master only.
//
// Ports:
//   sys_clk, rst             clock; asynchronous active-high reset
//   initialized_i            DRAM calibration done; no new grants while low
//   m_cyc_i/m_stb_i/m_we_i   per-master Wishbone request
//   m_addr_i/m_data_i        packed per-master address / write data (master i = slice i)
//   m_data_o, m_ack_o        shared read data, one-hot per-master ack pulse
//   s_*_o / s_data_i/s_ack_i registered request toward the wrapper, response from it
//   grant_o, busy_o          one-hot current owner, transaction in flight
//   timeout_o                sticky watchdog flag (only with ARB_TIMEOUT_EN)
//
// Optional feature: define ARB_TIMEOUT_EN to abandon a transaction after TIMEOUT_CYCLES cycles
// without s_ack_i. The abandoned master is acked with all-ones data.
module wb_dram_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned WORD_SIZE      = 256,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                              sys_clk,
  input  logic                              rst,
  input  logic                              initialized_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
  output logic [WORD_SIZE-1:0]              m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WORD_SIZE-1:0]              s_data_o,
  input  logic [WORD_SIZE-1:0]              s_data_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
`ifdef ARB_TIMEOUT_EN
  output logic                              timeout_o,
`endif
  output logic                              busy_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StWaitAck, StRelease} state_e;

  state_e                 r_state, w_state_nxt;
  logic [IdxW-1:0]        r_last, w_last_nxt;
  logic [IdxW-1:0]        r_gidx, w_gidx_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_ack, w_ack_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_cyc, w_cyc_nxt;
  logic                   r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic [WORD_SIZE-1:0]   r_wdata, w_wdata_nxt;
  logic [WORD_SIZE-1:0]   r_rdata, w_rdata_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_found;
  logic [IdxW-1:0]        w_win;
  logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_MASTERS];
  logic [WORD_SIZE-1:0]   w_data_arr [NUM_MASTERS];

  // Unpack the per-master address and data buses.
  always_comb begin : p_unpack
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_addr_arr[i] = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_data_arr[i] = m_data_i[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Round-robin search starting one past the last winner. The last candidate examined is the
  // previous winner itself, so it only wins again when nobody else is requesting.
  always_comb begin : p_pick
    int unsigned v_idx;
    v_idx   = 0;
    w_req   = m_cyc_i & m_stb_i;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      v_idx = (int'(r_last) + k) % NUM_MASTERS;
      if (!w_found && w_req[IdxW'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = IdxW'(v_idx);
      end
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gidx_nxt  = r_gidx;
    w_grant_nxt = r_grant;
    w_ack_nxt   = '0;
    w_busy_nxt  = r_busy;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
`endif
    unique case (r_state)
      StIdle: begin
        if (initialized_i && w_found) begin
          w_state_nxt = StWaitAck;
          w_last_nxt  = w_win;
          w_gidx_nxt  = w_win;
          w_grant_nxt = NUM_MASTERS'(1) << w_win;
          w_busy_nxt  = 1'b1;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = m_we_i[w_win];
          w_addr_nxt  = w_addr_arr[w_win];
          w_wdata_nxt = w_data_arr[w_win];
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      StWaitAck: begin
        if (s_ack_i) begin
          w_state_nxt = StRelease;
          w_cyc_nxt   = 1'b0;
          w_rdata_nxt = s_data_i;
          w_ack_nxt   = NUM_MASTERS'(1) << r_gidx;
        end
`ifdef ARB_TIMEOUT_EN
        // A real ack in the same cycle as the limit takes priority over the watchdog.
        else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = StRelease;
          w_cyc_nxt     = 1'b0;
          w_rdata_nxt   = '1;
          w_ack_nxt     = NUM_MASTERS'(1) << r_gidx;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      StRelease: begin
        // Wait for the owner to drop stb so the same request is never issued twice.
        if (!m_stb_i[r_gidx]) begin
          w_state_nxt = StIdle;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin : p_regs
    if (rst) begin
      r_state   <= StIdle;
      r_last    <= IdxW'(NUM_MASTERS - 1);
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gidx    <= w_gidx_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_cyc     <= w_cyc_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  // cyc and stb always move together toward the wrapper.
  assign s_cyc_o  = r_cyc;
  assign s_stb_o  = r_cyc;
  assign s_we_o   = r_we;
  assign s_addr_o = r_addr;
  assign s_data_o = r_wdata;
  assign m_data_o = r_rdata;
  assign m_ack_o  = r_ack;
  assign grant_o  = r_grant;
  assign busy_o   = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign timeout_o = r_timeout;
`endif

endmodule

// File: tb/tb_wb_dram_arbiter.sv
// Self-checking bench for wb_dram_arbiter: randomized masters and slave, round-robin reference
// model, and an ack/data scoreboard checked by an independent monitor.
module tb_wb_dram_arbiter;
  localparam int N  = 3;
  localparam int W  = 256;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic [N-1:0] cyc = '0, stb = '0, we = '0;
  logic [AW-1:0] addr [N];
  logic [W-1:0] wdata [N];
  logic [N*AW-1:0] m_addr_i;
  logic [N*W-1:0] m_data_i;
  logic [W-1:0] m_data_o, s_data_o;
  logic [W-1:0] s_data_i = '0;
  logic [N-1:0] m_ack_o, grant_o;
  logic s_cyc_o, s_stb_o, s_we_o, busy_o;
  logic s_ack_i = 1'b0;
  logic [AW-1:0] s_addr_o;
`ifdef ARB_TIMEOUT_EN
  logic timeout_o;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_addr_i[i*AW +: AW] = addr[i];
      m_data_i[i*W +: W]   = wdata[i];
    end
  end

  wb_dram_arbiter #(
    .NUM_MASTERS(N), .WORD_SIZE(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(clk), .rst(rst), .initialized_i(init),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o),
`ifdef ARB_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Round-robin rule: first requester found scanning upward from the previous winner + 1.
  function automatic int pick(input logic [N-1:0] req, input int from);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Master driver controls
  logic [N-1:0] pend = '0, go = '0, auto_en = '0;
  int gap [N];
  int wt [N];
  bit cont = 1'b0;

  // Slave / model state
  bit slave_en = 1'b1;
  int fixed_delay = -1;
  bit fixed_data_en = 1'b0;
  logic [W-1:0] fixed_data = '0;
  typedef struct { int m; logic [W-1:0] d; } exp_t;
  exp_t exp_q[$];
  int gq[$];
  int last = N - 1;
  int cur_m = 0;
  int sl_cnt = -1;
  logic [N-1:0] prev_req = '0, prev_ack = '0;
  bit prev_stb = 1'b0, prev_init = 1'b0;

  // Master driver: updates requests just after each rising edge.
  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; wdata[i] = '0; gap[i] = 0; wt[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend = '0; cyc = '0; stb = '0; go = '0;
        for (int i = 0; i < N; i++) gap[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (pend[i]) begin
            if (m_ack_o[i]) begin
              pend[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
              gap[i] = cont ? 1 : int'($urandom_range(1, 3));
            end else if (++wt[i] > 2000) begin
              errors++; checks++;
              $display("FAIL master%0d_ack_wait: got no ack expected ack within 2000 cycles", i);
              pend[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
            end
          end else if (gap[i] > 0) begin
            gap[i]--;
          end else if (auto_en[i] || go[i]) begin
            if (auto_en[i]) begin
              we[i] = 1'($urandom_range(0, 1));
              addr[i] = $urandom();
              wdata[i] = rand_word();
            end
            go[i] = 1'b0; cyc[i] = 1'b1; stb[i] = 1'b1; pend[i] = 1'b1; wt[i] = 0;
          end
        end
      end
    end
  end

  // Model + slave + monitor, all on the falling edge.
  initial begin
    exp_t e;
    int w;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = N - 1; sl_cnt = -1; s_ack_i = 1'b0; exp_q.delete();
        prev_stb = 1'b0; prev_req = '0; prev_init = 1'b0; prev_ack = '0;
      end else begin
        if (prev_ack != '0) check("ack_single_cycle", W'(m_ack_o), W'(0));
        if (m_ack_o != '0) begin
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_ack: got %b expected no ack", m_ack_o);
          end else begin
            e = exp_q.pop_front();
            check("ack_steer", W'(m_ack_o), W'(1) << e.m);
            check("ack_data", m_data_o, e.d);
          end
        end
        if (s_stb_o && !prev_stb) begin
          check("grant_requested", W'(prev_req & grant_o), W'(grant_o));
          check("grant_while_init", W'(prev_init), W'(1));
          w = pick(prev_req, last);
          if (w >= 0) begin
            check("grant_rr", W'(grant_o), W'(1) << w);
            check("issue_we", W'(s_we_o), W'(we[w]));
            check("issue_addr", W'(s_addr_o), W'(addr[w]));
            check("issue_data", s_data_o, wdata[w]);
            cur_m = w; last = w; gq.push_back(w);
          end
        end
        if (s_ack_i) begin
          s_ack_i = 1'b0;
        end else if (slave_en && s_stb_o) begin
          if (sl_cnt < 0) sl_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
          if (sl_cnt == 0) begin
            s_ack_i = 1'b1;
            s_data_i = fixed_data_en ? fixed_data : rand_word();
            e.m = cur_m; e.d = s_data_i;
            exp_q.push_back(e);
            sl_cnt = -1;
          end else begin
            sl_cnt--;
          end
        end
        prev_req = cyc & stb; prev_stb = s_stb_o; prev_init = init; prev_ack = m_ack_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((pend | go) != '0 || busy_o) begin
      tick();
      if (++n > 3000) begin
        errors++; checks++;
        $display("FAIL %s: got busy after 3000 cycles expected idle", name);
        break;
      end
    end
  endtask

  task automatic wait_grants(input int cnt, input string name);
    int n;
    n = 0;
    while (gq.size() < cnt) begin
      tick();
      if (++n > 5000) begin
        errors++; checks++;
        $display("FAIL %s: got %0d grants expected %0d", name, gq.size(), cnt);
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) tick();
    // Reset state
    check("rst_s_cyc", W'(s_cyc_o), W'(0));
    check("rst_s_stb", W'(s_stb_o), W'(0));
    check("rst_grant", W'(grant_o), W'(0));
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_ack", W'(m_ack_o), W'(0));
    check("rst_m_data", m_data_o, W'(0));
    check("rst_s_data", s_data_o, W'(0));
    rst = 1'b0;

    // Calibration gating
    we[0] = 1'b1; addr[0] = '0; wdata[0] = {32{8'hA5}}; go[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("gate_no_stb", W'(s_stb_o), W'(0));
    end
    init = 1'b1;
    tick();
    check("gate_stb", W'(s_stb_o), W'(1));
    check("gate_addr", W'(s_addr_o), W'(0));
    check("gate_data", s_data_o, {32{8'hA5}});
    wait_done("gate_done");

    // Single read round-trip with a fixed slave response
    fixed_delay = 5; fixed_data_en = 1'b1; fixed_data = {32{8'h5A}};
    we[1] = 1'b0; addr[1] = 32'h80; wdata[1] = rand_word(); go[1] = 1'b1;
    n = 0;
    while (m_ack_o == '0 && n < 100) begin tick(); n++; end
    check("rt_ack", W'(m_ack_o), W'(3'b010));
    check("rt_data", m_data_o, {32{8'h5A}});
    tick();
    check("rt_ack_pulse", W'(m_ack_o), W'(0));
    wait_done("rt_done");
    check("rt_grant_clear", W'(grant_o), W'(0));
    fixed_delay = -1; fixed_data_en = 1'b0;

    // Round-robin from a fresh pointer with all masters continuously requesting
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    gq.delete(); cont = 1'b1; auto_en = '1;
    wait_grants(6, "rr_grants");
    for (int k = 0; k < 6 && k < gq.size(); k++) check("rr_order", W'(gq[k]), W'(k % 3));
    cont = 1'b0;
    wait_grants(60, "random_grants");
    auto_en = '0;
    wait_done("random_done");

    // Ack steering with two simultaneous requests
    we[0] = 1'b1; addr[0] = $urandom(); wdata[0] = rand_word();
    we[2] = 1'b0; addr[2] = $urandom(); wdata[2] = rand_word();
    go = 3'b101;
    wait_done("steer_done");

    // Reset while waiting for the slave ack
    slave_en = 1'b0;
    we[2] = 1'b1; addr[2] = 32'h40; go[2] = 1'b1;
    n = 0;
    while (!busy_o && n < 100) begin tick(); n++; end
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_mid_cyc", W'(s_cyc_o), W'(0));
    check("rst_mid_grant", W'(grant_o), W'(0));
    check("rst_mid_busy", W'(busy_o), W'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_ack", W'(m_ack_o), W'(0));
    end
    rst = 1'b0; slave_en = 1'b1; gq.delete();
    we[0] = 1'b0; addr[0] = 32'h100; we[2] = 1'b0; addr[2] = 32'h200;
    go = 3'b101;
    wait_done("post_rst_done");
    if (gq.size() >= 2) begin
      check("post_rst_first", W'(gq[0]), W'(0));
      check("post_rst_second", W'(gq[1]), W'(2));
    end else begin
      errors++; checks++;
      $display("FAIL post_rst_grants: got %0d grants expected 2", gq.size());
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog with a silent slave
    begin
      exp_t e;
      slave_en = 1'b0;
      e.m = 0; e.d = '1;
      exp_q.push_back(e);
      we[0] = 1'b0; addr[0] = 32'h300; go[0] = 1'b1;
      cnt = 0; n = 0;
      do begin
        tick(); n++;
        if (s_cyc_o) cnt++;
      end while ((pend[0] || go[0]) && n < 200);
      check("to_wait_cycles", W'(cnt), W'(TO));
      check("to_s_cyc", W'(s_cyc_o), W'(0));
      check("to_flag", W'(timeout_o), W'(1));
      wait_done("to_done");
      repeat (5) tick();
      check("to_flag_sticky", W'(timeout_o), W'(1));
      slave_en = 1'b1;
    end
`endif

    repeat (5) tick();
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/wb_dram_arbiter.md
Name: wb_dram_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone slave port of the DRAM wrapper among NUM_MASTERS requesters (for example a CPU data port, a DMA engine and a video reader).
- Sits between the masters and the DRAM wrapper, in the sys_clk domain.
- Grants one complete transaction at a time: cyc/stb asserted, then ack.
- Registers the winning request toward the wrapper and routes the ack and read data back to the granted master only.

Parameters:
- NUM_MASTERS, 3: number of requesters (2..8).
- WORD_SIZE, 256: data width in bits. Must match the wrapper.
- ADDR_WIDTH, 32: byte address width.
- TIMEOUT_CYCLES, 4096: watchdog limit, in cycles, while waiting for the slave ack. Used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- initialized_i  in  1  DRAM calibration done, from the wrapper.
- m_cyc_i  in  NUM_MASTERS  per-master bus cycle.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice i.
- m_data_i  in  NUM_MASTERS*WORD_SIZE  packed write data.
- m_data_o  out  WORD_SIZE  read data, shared by all masters; valid only with that master's ack.
- m_ack_o  out  NUM_MASTERS  per-master ack, one-hot pulse.
- s_cyc_o  out  1  cycle signal to the wrapper.
- s_stb_o  out  1  strobe to the wrapper.
- s_we_o  out  1  write enable to the wrapper.
- s_addr_o  out  ADDR_WIDTH  address to the wrapper.
- s_data_o  out  WORD_SIZE  write data to the wrapper.
- s_data_i  in  WORD_SIZE  read data from the wrapper.
- s_ack_i  in  1  ack from the wrapper.
- grant_o  out  NUM_MASTERS  one-hot current owner; zero when idle.
- busy_o  out  1  a transaction is in flight.

Behaviour:
- Reset values:
  - all outputs 0, including m_data_o and s_data_o;
  - state IDLE;
  - round-robin pointer last_grant = NUM_MASTERS-1, so master 0 has first priority.
- A master is "requesting" when m_cyc_i[i] and m_stb_i[i] are both high.
- Master rules:
  - hold cyc, stb, we, addr and data stable until its m_ack_o pulse;
  - deassert stb for at least one cycle between transactions.
- Arbitration:
  - Search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - The first requesting master wins.
  - Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- States:
  - IDLE: transition to ISSUE only when initialized_i=1 and at least one master is requesting. On that edge:
    - latch the winner's we, addr and data into s_*_o;
    - set grant_o and last_grant;
    - assert s_cyc_o=s_stb_o=1 and busy_o=1.
  - ISSUE/WAIT_ACK: hold s_* stable. On s_ack_i=1:
    - deassert s_cyc_o and s_stb_o;
    - register m_data_o <= s_data_i (write transactions too);
    - pulse m_ack_o[grant]=1 for exactly one cycle;
    - go to RELEASE.
  - RELEASE:
    - m_ack_o is 0 in this state.
    - If m_stb_i[grant]=0: clear grant_o and busy_o, go to IDLE.
    - Otherwise stay in RELEASE, so the same request is never re-issued.
- Latency:
  - Request to s_stb_o: 1 cycle.
  - s_ack_i to m_ack_o: 1 cycle.
  - Minimum gap between consecutive grants: 3 cycles.
- Simultaneous events:
  - A new request arriving while busy waits; it is evaluated in IDLE.
  - A master dropping cyc mid-transaction is not aborted toward the slave. Its ack is still pulsed, and the master is expected to ignore it.
- initialized_i falling while busy: the current transaction completes. No new grants are made until it rises again.
- rst asserted mid-transaction: everything returns to reset values immediately, s_cyc_o falls asynchronously, and no ack is produced.
- s_ack_i in IDLE or RELEASE is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES, the transaction is abandoned:
    - s_cyc_o and s_stb_o deassert;
    - m_ack_o[grant] pulses with m_data_o = all-ones;
    - sticky output port timeout_o (1 bit, reset 0) sets; it clears only on rst.
  - The arbiter then moves to RELEASE as normal.
- Undefined: no counter and no timeout_o port. The arbiter waits for s_ack_i indefinitely.

Test Plan:
- Gating: initialized_i=0 with m0 requesting a write for 50 cycles -> s_stb_o stays 0. Raise initialized_i -> s_stb_o=1 one cycle later, s_addr_o=0x00000000, s_data_o={32{8'hA5}}.
- Single read round-trip: m1 read at addr 0x80; slave acks 5 cycles later with {32{8'h5A}} -> m_ack_o=3'b010 for exactly one cycle, m_data_o={32{8'h5A}}, grant_o returns to 0.
- Round-robin: m0, m1 and m2 request simultaneously and continuously re-request after each ack -> grant order 0,1,2,0,1,2. No master is granted twice while another waits.
- Ack steering: m0 write and m2 read pending at the same time -> only m_ack_o[0] pulses during the first transaction. m_ack_o[2] pulses only after the second s_ack_i. Never more than one m_ack_o bit is high.
- Reset mid-operation: assert rst during WAIT_ACK -> on the same edge s_cyc_o=0, grant_o=0, busy_o=0, no m_ack_o pulse. After release, m0 wins first.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and the slave never acking -> after 16 wait cycles: s_cyc_o=0, m_ack_o pulses with m_data_o=all-ones, timeout_o=1 and stays set.
